// File: rtl/i2s_mix_sched.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_mix_sched
//  Brief    : Shares one accumulator/saturator between NCH i2sin receivers.
//             Captures per-side samples into holding slots, sums the current
//             side one channel per cycle and presents a saturated mix on a
//             valid/ready interface. Sides alternate left, right, left, ...
//  Revision : 1.0 - initial release
// ============================================================================
module i2s_mix_sched #(
   parameter int BITS_PRECISION = 4,
   parameter int NCH            = 4,
   parameter int TIMEOUT        = 64
) (
   input  logic                          sck,
   input  logic                          rst,
   input  logic [NCH*BITS_PRECISION-1:0] ch_data,
   input  logic [NCH-1:0]                ch_lrn,
   input  logic [NCH-1:0]                ch_en,
   input  logic [NCH-1:0]                mute,
   output logic [BITS_PRECISION-1:0]     mix_data,
   output logic                          mix_lrn,
   output logic                          mix_valid,
   input  logic                          mix_ready,
   output logic [NCH-1:0]                overrun,
   output logic                          missed,
   input  logic                          clr_flags
);

   localparam int c_iw    = $clog2(NCH);
   localparam int c_acc_w = BITS_PRECISION + c_iw;
   localparam int c_tw    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic signed [c_acc_w-1:0] c_sat_max = c_acc_w'((2 ** (BITS_PRECISION - 1)) - 1);
   localparam logic signed [c_acc_w-1:0] c_sat_min = c_acc_w'(-(2 ** (BITS_PRECISION - 1)));

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   state_t                               state_q, state_d;
   logic [NCH-1:0][BITS_PRECISION-1:0]   slot_l_q, slot_l_d;
   logic [NCH-1:0][BITS_PRECISION-1:0]   slot_r_q, slot_r_d;
   logic [NCH-1:0]                       pend_l_q, pend_l_d;
   logic [NCH-1:0]                       pend_r_q, pend_r_d;
   logic [NCH-1:0]                       overrun_q, overrun_d;
   logic                                 missed_q, missed_d;
   logic [c_iw-1:0]                      idx_q, idx_d;
   logic [c_acc_w-1:0]                   acc_q, acc_d;
   logic [c_tw-1:0]                      tcnt_q, tcnt_d;
   logic                                 side_q, side_d;
   logic [BITS_PRECISION-1:0]            mix_data_q, mix_data_d;
   logic                                 mix_lrn_q, mix_lrn_d;
   logic                                 mix_valid_q, mix_valid_d;

   logic [NCH-1:0]                       w_pend_side;
   logic                                 w_ready;
   logic                                 w_any_live;
   logic [BITS_PRECISION-1:0]            w_slot;
   logic [c_acc_w-1:0]                   w_term;
   logic [BITS_PRECISION-1:0]            w_sat;
   logic                                 w_consumed;

   assign w_pend_side = side_q ? pend_l_q : pend_r_q;
   assign w_any_live  = |(~mute);
   // An all-muted configuration never becomes ready, so nothing is emitted
   assign w_ready     = w_any_live && ((w_pend_side | mute) == {NCH{1'b1}});
   assign w_slot      = side_q ? slot_l_q[idx_q] : slot_r_q[idx_q];
   assign w_term      = (w_pend_side[idx_q] && !mute[idx_q]) ?
                        {{c_iw{w_slot[BITS_PRECISION-1]}}, w_slot} : '0;

   // Clamp the wide accumulator into the output sample range
   always_comb begin
      w_sat = acc_q[BITS_PRECISION-1:0];
      if ($signed(acc_q) > c_sat_max) begin
         w_sat = c_sat_max[BITS_PRECISION-1:0];
      end else if ($signed(acc_q) < c_sat_min) begin
         w_sat = c_sat_min[BITS_PRECISION-1:0];
      end
   end

   // Slot capture, consumption of pending bits and overrun detection
   always_comb begin
      slot_l_d   = slot_l_q;
      slot_r_d   = slot_r_q;
      pend_l_d   = pend_l_q;
      pend_r_d   = pend_r_q;
      overrun_d  = clr_flags ? '0 : overrun_q;
      w_consumed = 1'b0;
      if (state_q == ST_ACC) begin
         if (side_q) pend_l_d[idx_q] = 1'b0;
         else        pend_r_d[idx_q] = 1'b0;
      end
      // A strobe on the slot being consumed re-arms it without an overrun
      for (int k = 0; k < NCH; k++) begin
         w_consumed = (state_q == ST_ACC) && (idx_q == c_iw'(k)) && (side_q == ch_lrn[k]);
         if (ch_en[k]) begin
            if (ch_lrn[k]) begin
               if (pend_l_q[k] && !w_consumed) overrun_d[k] = 1'b1;
               slot_l_d[k] = ch_data[k*BITS_PRECISION +: BITS_PRECISION];
               pend_l_d[k] = 1'b1;
            end else begin
               if (pend_r_q[k] && !w_consumed) overrun_d[k] = 1'b1;
               slot_r_d[k] = ch_data[k*BITS_PRECISION +: BITS_PRECISION];
               pend_r_d[k] = 1'b1;
            end
         end
      end
   end

   // Scheduler FSM: wait for the side, accumulate one channel per cycle, hand off
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      tcnt_d      = tcnt_q;
      side_d      = side_q;
      missed_d    = clr_flags ? 1'b0 : missed_q;
      mix_data_d  = mix_data_q;
      mix_lrn_d   = mix_lrn_q;
      mix_valid_d = mix_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (w_ready) begin
               state_d = ST_ACC;
               idx_d   = '0;
               acc_d   = '0;
               tcnt_d  = '0;
            end else if ((|w_pend_side) && w_any_live) begin
               if (tcnt_q == c_tw'(TIMEOUT - 1)) begin
                  state_d  = ST_ACC;
                  idx_d    = '0;
                  acc_d    = '0;
                  tcnt_d   = '0;
                  missed_d = 1'b1;
               end else begin
                  tcnt_d = tcnt_q + c_tw'(1);
               end
            end
         end
         ST_ACC: begin
            acc_d = acc_q + w_term;
            if (idx_q == c_iw'(NCH - 1)) begin
               state_d = ST_OUT;
            end else begin
               idx_d = idx_q + c_iw'(1);
            end
         end
         ST_OUT: begin
            // First OUT cycle loads the result; later cycles hold it for the consumer
            if (!mix_valid_q) begin
               mix_data_d  = w_sat;
               mix_lrn_d   = side_q;
               mix_valid_d = 1'b1;
            end else if (mix_ready) begin
               mix_valid_d = 1'b0;
               side_d      = ~side_q;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge sck or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         slot_l_q    <= '0;
         slot_r_q    <= '0;
         pend_l_q    <= '0;
         pend_r_q    <= '0;
         overrun_q   <= '0;
         missed_q    <= 1'b0;
         idx_q       <= '0;
         acc_q       <= '0;
         tcnt_q      <= '0;
         side_q      <= 1'b1;
         mix_data_q  <= '0;
         mix_lrn_q   <= 1'b1;
         mix_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_l_q    <= slot_l_d;
         slot_r_q    <= slot_r_d;
         pend_l_q    <= pend_l_d;
         pend_r_q    <= pend_r_d;
         overrun_q   <= overrun_d;
         missed_q    <= missed_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         tcnt_q      <= tcnt_d;
         side_q      <= side_d;
         mix_data_q  <= mix_data_d;
         mix_lrn_q   <= mix_lrn_d;
         mix_valid_q <= mix_valid_d;
      end
   end

   assign mix_data  = mix_data_q;
   assign mix_lrn   = mix_lrn_q;
   assign mix_valid = mix_valid_q;
   assign overrun   = overrun_q;
   assign missed    = missed_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_mix_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_mix_sched
//  Brief    : Self-checking bench for i2s_mix_sched with a transaction-level
//             reference model of the slots and the saturated mix.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_mix_sched;
   localparam int B   = 4;
   localparam int NCH = 4;
   localparam int TMO = 8;

   logic             sck = 1'b0;
   logic             rst = 1'b0;
   logic [NCH*B-1:0] ch_data = '0;
   logic [NCH-1:0]   ch_lrn = '0;
   logic [NCH-1:0]   ch_en = '0;
   logic [NCH-1:0]   mute = '0;
   logic [B-1:0]     mix_data;
   logic             mix_lrn;
   logic             mix_valid;
   logic             mix_ready = 1'b0;
   logic [NCH-1:0]   overrun;
   logic             missed;
   logic             clr_flags = 1'b0;

   always #5 sck = ~sck;

   i2s_mix_sched #(.BITS_PRECISION(B), .NCH(NCH), .TIMEOUT(TMO)) dut (
      .sck(sck), .rst(rst), .ch_data(ch_data), .ch_lrn(ch_lrn), .ch_en(ch_en),
      .mute(mute), .mix_data(mix_data), .mix_lrn(mix_lrn), .mix_valid(mix_valid),
      .mix_ready(mix_ready), .overrun(overrun), .missed(missed), .clr_flags(clr_flags)
   );

   int             n_checks = 0;
   int             n_fail = 0;
   // Reference model: per side (1 = left) per channel value and pending flag
   int             m_val [2][NCH];
   bit             m_pend[2][NCH];
   logic [NCH-1:0] m_ovr = '0;
   int             m_side = 1;
   int             exp_data = 0;

   task automatic tick();
      @(posedge sck);
      #1;
   endtask

   task automatic check(input logic signed [31:0] obs, input logic signed [31:0] exp, input string tag);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int sat(input int s);
      if (s > (2 ** (B - 1)) - 1) return (2 ** (B - 1)) - 1;
      if (s < -(2 ** (B - 1)))    return -(2 ** (B - 1));
      return s;
   endfunction

   task automatic send(input int side, input int a, input int b, input int c, input int d,
                       input logic [NCH-1:0] en);
      int v[NCH];
      v = '{a, b, c, d};
      for (int k = 0; k < NCH; k++) begin
         ch_data[k*B +: B] = B'(v[k]);
         if (en[k]) begin
            if (m_pend[side][k]) m_ovr[k] = 1'b1;
            m_val[side][k]  = v[k];
            m_pend[side][k] = 1'b1;
         end
      end
      ch_lrn = (side != 0) ? '1 : '0;
      ch_en  = en;
      tick();
      ch_en  = '0;
   endtask

   // Mix of one side: sum of pending unmuted samples, saturated; all slots of the side drain
   task automatic model_mix(input int side);
      int s;
      s = 0;
      for (int k = 0; k < NCH; k++) begin
         if (m_pend[side][k] && !mute[k]) s += m_val[side][k];
         m_pend[side][k] = 1'b0;
      end
      exp_data = sat(s);
   endtask

   task automatic wait_valid(input int exp_lat, input string tag);
      int n;
      n = 0;
      while (mix_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check(n, exp_lat, {tag, "_lat"});
   endtask

   task automatic check_out(input string tag);
      check($signed(mix_data), exp_data, {tag, "_data"});
      check(mix_lrn, m_side, {tag, "_lrn"});
   endtask

   task automatic accept(input int delay, input string tag);
      for (int i = 0; i < delay; i++) begin
         tick();
         check($signed(mix_data), exp_data, {tag, "_hold"});
      end
      mix_ready = 1'b1;
      tick();
      mix_ready = 1'b0;
      check(mix_valid, 0, {tag, "_drop"});
      m_side = 1 - m_side;
   endtask

   task automatic mix(input int a, input int b, input int c, input int d,
                      input logic [NCH-1:0] en, input int lat, input int delay, input string tag);
      send(m_side, a, b, c, d, en);
      model_mix(m_side);
      wait_valid(lat, tag);
      check_out(tag);
      accept(delay, tag);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: observed stuck simulation expected completion");
      $fatal(1, "simulation time limit");
   end

   initial begin
      for (int s = 0; s < 2; s++)
         for (int k = 0; k < NCH; k++) begin
            m_val[s][k]  = 0;
            m_pend[s][k] = 1'b0;
         end

      // Reset state
      tick();
      tick();
      check(mix_valid, 0, "rst_valid");
      check($signed(mix_data), 0, "rst_data");
      check(mix_lrn, 1, "rst_lrn");
      check(overrun, 0, "rst_overrun");
      check(missed, 0, "rst_missed");
      rst = 1'b1;
      tick();

      // Basic left and right mixes, NCH+2 edge latency
      mix(1, 2, 3, -1, 4'hF, NCH + 2, 0, "basic_l");
      mix(0, 0, 0, 1, 4'hF, NCH + 2, 0, "basic_r");

      // Saturation at both rails
      mix(7, 7, 7, 7, 4'hF, NCH + 2, 0, "sat_pos");
      mix(0, 0, 0, 0, 4'hF, NCH + 2, 0, "zero_r1");
      mix(-8, -8, -8, -8, 4'hF, NCH + 2, 0, "sat_neg");
      mix(0, 0, 0, 0, 4'hF, NCH + 2, 0, "zero_r2");

      // Muted channel is not waited for
      mute = 4'b1000;
      mix(2, 2, 2, 0, 4'b0111, NCH + 2, 0, "mute_l");
      check(missed, 0, "mute_missed");
      mix(0, 0, 0, 0, 4'b0111, NCH + 2, 0, "mute_r");
      mute = 4'b0000;

      // Timeout with two unmuted channels absent
      mix(3, 3, 0, 0, 4'b0011, TMO + NCH + 1, 0, "tmo");
      check(missed, 1, "tmo_missed");
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      check(missed, 0, "tmo_clr");
      mix(0, 0, 0, 0, 4'hF, NCH + 2, 0, "zero_r3");

      // Back-pressure with an overwrite into the next left slot
      send(m_side, 1, 1, 1, 1, 4'hF);
      model_mix(m_side);
      wait_valid(NCH + 2, "ovr");
      check_out("ovr");
      for (int i = 0; i < 10; i++) begin
         if (i == 2)      send(1, 5, 0, 0, 0, 4'b0001);
         else if (i == 5) send(1, 6, 0, 0, 0, 4'b0001);
         else             tick();
         check($signed(mix_data), exp_data, "ovr_hold");
         check(mix_valid, 1, "ovr_valid_hold");
      end
      check(overrun, m_ovr, "ovr_flag");
      accept(0, "ovr");
      mix(0, 0, 0, 0, 4'hF, NCH + 2, 0, "zero_r4");
      mix(0, 1, 0, -1, 4'b1110, NCH + 2, 0, "ovr_later");
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      m_ovr = '0;
      check(overrun, 0, "ovr_clr");

      // Reset pulse in the middle of accumulation
      send(m_side, 3, 3, 3, 3, 4'hF);
      tick();
      tick();
      tick();
      rst = 1'b0;
      #2;
      check(mix_valid, 0, "midrst_valid");
      check(mix_lrn, 1, "midrst_lrn");
      rst = 1'b1;
      for (int s = 0; s < 2; s++)
         for (int k = 0; k < NCH; k++) m_pend[s][k] = 1'b0;
      m_side = 1;
      tick();
      mix(1, 1, 1, 1, 4'hF, NCH + 2, 0, "post_rst");
      check(overrun, 0, "post_rst_overrun");

      // Randomized mixes with random mutes and back-pressure
      for (int it = 0; it < 24; it++) begin
         logic [NCH-1:0] mt;
         logic [NCH-1:0] en;
         int v[NCH];
         mt = NCH'($urandom_range(15));
         if (mt == '1) mt = '0;
         mute = mt;
         en = ~mt | (NCH'($urandom_range(15)) & mt);
         for (int k = 0; k < NCH; k++) v[k] = int'($urandom_range(15)) - 8;
         mix(v[0], v[1], v[2], v[3], en, NCH + 2, int'($urandom_range(3)), "rand");
      end
      mute = '0;
      check(overrun, 0, "rand_overrun");
      check(missed, 0, "rand_missed");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
